// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage pipeline: load-use bubbles, MEM-stage branch flushes
// and data-memory wait freezes, with saturating stall/flush counters and a sticky timeout flag.
module pipe_hazard_ctrl #(
  parameter int unsigned TO_W        = 4,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             IDEX_MemR,
  input  logic [4:0]       IDEX_rt,
  input  logic             EXMEM_Branch,
  input  logic             EXMEM_zero,
  input  logic             EXMEM_MemR,
  input  logic             EXMEM_MemW,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             PC_We,
  output logic             PC_Src,
  output logic             IFID_We,
  output logic             IFID_Flush,
  output logic             IDEX_We,
  output logic             IDEX_Flush,
  output logic             EXMEM_We,
  output logic             EXMEM_Flush,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic S_RUN   = 1'b0;
  localparam logic S_MWAIT = 1'b1;

  localparam logic [TO_W:0] L_TIMEOUT = (TO_W + 1)'(MEM_TIMEOUT);
  localparam logic [TO_W:0] L_ONE     = (TO_W + 1)'(1);

  logic             r_state;
  logic [TO_W-1:0]  r_to;
  logic             r_mem_err;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic             w_state_d;
  logic [TO_W-1:0]  w_to_d;
  logic             w_err_d;
  logic             w_flush_inc;
  logic             w_memop;
  logic             w_taken;
  logic             w_luh;
  logic             w_stuck;
  logic [TO_W:0]    w_to_inc;

  assign w_memop  = EXMEM_MemR | EXMEM_MemW;
  assign w_taken  = EXMEM_Branch & EXMEM_zero;
  assign w_luh    = IDEX_MemR & (IDEX_rt != 5'd0) & ((IDEX_rt == ID_rs) | (IDEX_rt == ID_rt));
  assign w_stuck  = w_memop & ~dmem_ready;
  assign w_to_inc = {1'b0, r_to} + L_ONE;

  always_comb begin
    dmem_req    = 1'b0;
    PC_We       = 1'b1;
    PC_Src      = 1'b0;
    IFID_We     = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_We     = 1'b1;
    IDEX_Flush  = 1'b0;
    EXMEM_We    = 1'b1;
    EXMEM_Flush = 1'b0;
    w_state_d   = r_state;
    w_to_d      = r_to;
    w_err_d     = r_mem_err;
    w_flush_inc = 1'b0;

    if (Rst) begin
      PC_We       = 1'b0;
      IFID_We     = 1'b0;
      IDEX_We     = 1'b0;
      EXMEM_We    = 1'b0;
      IFID_Flush  = 1'b1;
      IDEX_Flush  = 1'b1;
      EXMEM_Flush = 1'b1;
    end else if (r_state == S_RUN) begin
      dmem_req = w_memop;
      if (w_stuck) begin
        PC_We     = 1'b0;
        IFID_We   = 1'b0;
        IDEX_We   = 1'b0;
        EXMEM_We  = 1'b0;
        w_state_d = S_MWAIT;
        w_to_d    = TO_W'(1);
        if (L_TIMEOUT <= L_ONE) begin
          w_err_d = 1'b1;
        end
      end else if (w_taken) begin
        // A completed memop does not mask branch or load-use handling
        PC_Src      = 1'b1;
        IFID_Flush  = 1'b1;
        IDEX_Flush  = 1'b1;
        EXMEM_Flush = 1'b1;
        w_flush_inc = 1'b1;
      end else if (w_luh) begin
        PC_We      = 1'b0;
        IFID_We    = 1'b0;
        IDEX_Flush = 1'b1;
      end
    end else begin
      dmem_req = 1'b1;
      if (dmem_ready) begin
        w_state_d = S_RUN;
        w_to_d    = '0;
      end else begin
        PC_We    = 1'b0;
        IFID_We  = 1'b0;
        IDEX_We  = 1'b0;
        EXMEM_We = 1'b0;
        // Counter holds at the limit so it never wraps while the wait persists
        if (w_to_inc <= L_TIMEOUT) begin
          w_to_d = w_to_inc[TO_W-1:0];
        end
        if (w_to_inc >= L_TIMEOUT) begin
          w_err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state     <= S_RUN;
      r_to        <= '0;
      r_mem_err   <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state   <= w_state_d;
      r_to      <= w_to_d;
      r_mem_err <= w_err_d;
      if (!PC_We && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_flush_inc && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  assign mem_err   = r_mem_err;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios with literal expectations plus random
// traffic checked every cycle against an event-level model; a CNT_W=4 copy checks saturation.
module tb_pipe_hazard_ctrl;

  localparam int T = 15;

  logic Clk = 1'b0;
  logic Rst;
  logic [4:0] ID_rs, ID_rt, IDEX_rt;
  logic IDEX_MemR, EXMEM_Branch, EXMEM_zero, EXMEM_MemR, EXMEM_MemW, dmem_ready;

  logic dmem_req, PC_We, PC_Src, IFID_We, IFID_Flush, IDEX_We, IDEX_Flush, EXMEM_We, EXMEM_Flush;
  logic mem_err;
  logic [15:0] stall_cnt, flush_cnt;

  logic s_dmem_req, s_PC_We, s_PC_Src, s_IFID_We, s_IFID_Flush, s_IDEX_We, s_IDEX_Flush;
  logic s_EXMEM_We, s_EXMEM_Flush, s_mem_err;
  logic [3:0] s_stall_cnt, s_flush_cnt;

  always #5 Clk = ~Clk;

  pipe_hazard_ctrl #(.TO_W(4), .MEM_TIMEOUT(15), .CNT_W(16)) dut (
    .Clk(Clk), .Rst(Rst), .ID_rs(ID_rs), .ID_rt(ID_rt), .IDEX_MemR(IDEX_MemR),
    .IDEX_rt(IDEX_rt), .EXMEM_Branch(EXMEM_Branch), .EXMEM_zero(EXMEM_zero),
    .EXMEM_MemR(EXMEM_MemR), .EXMEM_MemW(EXMEM_MemW), .dmem_ready(dmem_ready),
    .dmem_req(dmem_req), .PC_We(PC_We), .PC_Src(PC_Src), .IFID_We(IFID_We),
    .IFID_Flush(IFID_Flush), .IDEX_We(IDEX_We), .IDEX_Flush(IDEX_Flush),
    .EXMEM_We(EXMEM_We), .EXMEM_Flush(EXMEM_Flush), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_hazard_ctrl #(.TO_W(4), .MEM_TIMEOUT(15), .CNT_W(4)) dut_small (
    .Clk(Clk), .Rst(Rst), .ID_rs(ID_rs), .ID_rt(ID_rt), .IDEX_MemR(IDEX_MemR),
    .IDEX_rt(IDEX_rt), .EXMEM_Branch(EXMEM_Branch), .EXMEM_zero(EXMEM_zero),
    .EXMEM_MemR(EXMEM_MemR), .EXMEM_MemW(EXMEM_MemW), .dmem_ready(dmem_ready),
    .dmem_req(s_dmem_req), .PC_We(s_PC_We), .PC_Src(s_PC_Src), .IFID_We(s_IFID_We),
    .IFID_Flush(s_IFID_Flush), .IDEX_We(s_IDEX_We), .IDEX_Flush(s_IDEX_Flush),
    .EXMEM_We(s_EXMEM_We), .EXMEM_Flush(s_EXMEM_Flush), .mem_err(s_mem_err),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  // Model state: waiting on memory, misses in the current access, sticky error, event counts
  bit m_valid = 1'b0;
  bit m_wait;
  int m_miss;
  bit m_err;
  int m_stall;
  int m_flush;

  // Control vector order: req, PC_We, PC_Src, IFID_We, IFID_Flush, IDEX_We, IDEX_Flush,
  // EXMEM_We, EXMEM_Flush
  always @(negedge Clk) begin : cmp
    logic [8:0] e;
    logic memop, taken, luh, stuck;
    memop = EXMEM_MemR | EXMEM_MemW;
    taken = EXMEM_Branch & EXMEM_zero;
    luh   = IDEX_MemR && (IDEX_rt != 0) && ((IDEX_rt == ID_rs) || (IDEX_rt == ID_rt));
    stuck = 1'b0;
    if (Rst) begin
      e = 9'b0_0_0_0_1_0_1_0_1;
    end else if (m_wait) begin
      e = dmem_ready ? 9'b1_1_0_1_0_1_0_1_0 : 9'b1_0_0_0_0_0_0_0_0;
    end else begin
      stuck = memop && !dmem_ready;
      if (stuck)      e = 9'b1_0_0_0_0_0_0_0_0;
      else if (taken) e = {memop, 8'b1111_1111};
      else if (luh)   e = {memop, 8'b0000_1110};
      else            e = {memop, 8'b1010_1010};
    end
    if (m_valid) begin
      chk("ctl", {dmem_req, PC_We, PC_Src, IFID_We, IFID_Flush, IDEX_We, IDEX_Flush,
                  EXMEM_We, EXMEM_Flush}, 32'(e));
      chk("mem_err", 32'(mem_err), 32'(m_err));
      chk("stall_cnt", 32'(stall_cnt), 32'(sat(m_stall, 65535)));
      chk("flush_cnt", 32'(flush_cnt), 32'(sat(m_flush, 65535)));
      chk("small_stall_cnt", 32'(s_stall_cnt), 32'(sat(m_stall, 15)));
      chk("small_flush_cnt", 32'(s_flush_cnt), 32'(sat(m_flush, 15)));
    end
    if (Rst) begin
      m_valid = 1'b1;
      m_wait  = 1'b0;
      m_miss  = 0;
      m_err   = 1'b0;
      m_stall = 0;
      m_flush = 0;
    end else if (m_valid) begin
      if (!e[7]) m_stall++;
      if (!m_wait && !stuck && taken) m_flush++;
      if (m_wait) begin
        if (dmem_ready) begin
          m_wait = 1'b0;
        end else begin
          m_miss++;
          if (m_miss >= T) m_err = 1'b1;
        end
      end else if (stuck) begin
        m_wait = 1'b1;
        m_miss = 1;
        if (m_miss >= T) m_err = 1'b1;
      end
    end
  end

  task automatic clr();
    ID_rs = 0; ID_rt = 0; IDEX_rt = 0; IDEX_MemR = 0;
    EXMEM_Branch = 0; EXMEM_zero = 0; EXMEM_MemR = 0; EXMEM_MemW = 0; dmem_ready = 0;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    clr();
    tick();
    Rst = 1'b0;
  endtask

  initial begin
    int kind;
    Rst = 1'b1;
    clr();
    tick();
    @(negedge Clk);
    chk("rst_pc_we", 32'(PC_We), 0);
    chk("rst_flushes", 32'({IFID_Flush, IDEX_Flush, EXMEM_Flush}), 32'h7);
    chk("rst_req", 32'(dmem_req), 0);
    tick();
    Rst = 1'b0;

    // Load-use stall
    IDEX_MemR = 1; IDEX_rt = 5; ID_rs = 5;
    @(negedge Clk);
    chk("luh_pc_we", 32'(PC_We), 0);
    chk("luh_ifid_we", 32'(IFID_We), 0);
    chk("luh_idex_flush", 32'(IDEX_Flush), 1);
    tick(); clr();
    @(negedge Clk);
    chk("luh_stall_cnt", 32'(stall_cnt), 1);
    tick();

    // Load into r0 is never a hazard
    IDEX_MemR = 1; IDEX_rt = 0; ID_rs = 0;
    @(negedge Clk);
    chk("r0_pc_we", 32'(PC_We), 1);
    tick(); clr();
    @(negedge Clk);
    chk("r0_stall_cnt", 32'(stall_cnt), 1);
    tick();

    // Taken branch overrides a simultaneous load-use
    EXMEM_Branch = 1; EXMEM_zero = 1; IDEX_MemR = 1; IDEX_rt = 5; ID_rs = 5;
    @(negedge Clk);
    chk("br_pc_src", 32'(PC_Src), 1);
    chk("br_pc_we", 32'(PC_We), 1);
    chk("br_flushes", 32'({IFID_Flush, IDEX_Flush, EXMEM_Flush}), 32'h7);
    tick(); clr();
    @(negedge Clk);
    chk("br_flush_cnt", 32'(flush_cnt), 1);
    chk("br_stall_cnt", 32'(stall_cnt), 1);
    tick();

    // Untaken branch leaves only the load-use stall
    EXMEM_Branch = 1; EXMEM_zero = 0; IDEX_MemR = 1; IDEX_rt = 5; ID_rt = 5;
    @(negedge Clk);
    chk("nbr_pc_src", 32'(PC_Src), 0);
    chk("nbr_pc_we", 32'(PC_We), 0);
    tick(); clr();
    @(negedge Clk);
    chk("nbr_stall_cnt", 32'(stall_cnt), 2);
    chk("nbr_flush_cnt", 32'(flush_cnt), 1);
    tick();

    // Memory wait: three not-ready cycles, then ready
    for (int i = 0; i < 4; i++) begin
      EXMEM_MemR = 1; dmem_ready = (i == 3);
      @(negedge Clk);
      chk("mw_req", 32'(dmem_req), 1);
      chk("mw_pc_we", 32'(PC_We), 32'(i == 3));
      tick();
    end
    clr();
    @(negedge Clk);
    chk("mw_stall_cnt", 32'(stall_cnt), 5);
    chk("mw_back_run", 32'({dmem_req, PC_We}), 32'b01);
    tick();

    // Timeout: error after fifteen missed cycles, sticky past completion
    do_reset();
    for (int i = 0; i < 20; i++) begin
      EXMEM_MemW = 1; dmem_ready = 0;
      @(negedge Clk);
      chk("to_mem_err", 32'(mem_err), 32'(i >= 15));
      tick();
    end
    dmem_ready = 1;
    @(negedge Clk);
    chk("to_release", 32'(PC_We), 1);
    chk("to_err_hold", 32'(mem_err), 1);
    tick(); clr();
    @(negedge Clk);
    chk("to_err_sticky", 32'(mem_err), 1);
    tick();

    // Reset in the second cycle of a wait
    do_reset();
    EXMEM_MemR = 1; dmem_ready = 0;
    tick();
    Rst = 1;
    @(negedge Clk);
    chk("rmw_req", 32'(dmem_req), 0);
    chk("rmw_we", 32'({PC_We, IFID_We, IDEX_We, EXMEM_We}), 0);
    chk("rmw_flush", 32'({IFID_Flush, IDEX_Flush, EXMEM_Flush}), 32'h7);
    tick();
    Rst = 0; clr();
    @(negedge Clk);
    chk("rmw_run", 32'({dmem_req, PC_We}), 32'b01);
    chk("rmw_stall_cnt", 32'(stall_cnt), 0);
    chk("rmw_mem_err", 32'(mem_err), 0);
    tick();

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      Rst          = ($urandom_range(0, 199) == 0);
      kind         = int'($urandom_range(0, 7));
      EXMEM_MemR   = (kind == 4);
      EXMEM_MemW   = (kind == 5);
      EXMEM_Branch = (kind >= 6);
      EXMEM_zero   = $urandom_range(0, 1) == 1;
      dmem_ready   = $urandom_range(0, 9) < 6;
      IDEX_MemR    = $urandom_range(0, 9) < 4;
      IDEX_rt      = 5'($urandom_range(0, 3));
      ID_rs        = 5'($urandom_range(0, 3));
      ID_rt        = 5'($urandom_range(0, 3));
      tick();
    end

    // Saturation of the narrow counter
    do_reset();
    for (int i = 0; i < 20; i++) begin
      IDEX_MemR = 1; IDEX_rt = 7; ID_rs = 7;
      tick();
    end
    clr();
    @(negedge Clk);
    chk("sat_small", 32'(s_stall_cnt), 15);
    chk("sat_wide", 32'(stall_cnt), 20);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives write-enable and flush controls of PC, IF/ID, ID/EX and EX/MEM registers.
- Handles three events: load-use hazards, taken branches resolved in MEM, and data-memory wait handshakes.
- Sits beside the pipeline registers; reads decoded ID fields plus ID/EX and EX/MEM control outputs.

Parameters:
- TO_W, 4, width of memory-wait timeout counter.
- MEM_TIMEOUT, 15, max cycles in MWAIT before the error flag is set; must be < 2^TO_W.
- CNT_W, 16, width of the stall and flush performance counters.

Ports:
- Clk  in  1  pipeline clock, rising edge.
- Rst  in  1  synchronous active-high reset.
- ID_rs  in  5  rs field of instruction in ID.
- ID_rt  in  5  rt field of instruction in ID.
- IDEX_MemR  in  1  ID/EX stage holds a load.
- IDEX_rt  in  5  destination register of the ID/EX load.
- EXMEM_Branch  in  1  EX/MEM holds a branch.
- EXMEM_zero  in  1  registered ALU zero of that branch.
- EXMEM_MemR  in  1  EX/MEM holds a load.
- EXMEM_MemW  in  1  EX/MEM holds a store.
- dmem_ready  in  1  data memory completes the access this cycle.
- dmem_req  out  1  data memory access request.
- PC_We  out  1  PC register update enable.
- PC_Src  out  1  1 = load branch target.
- IFID_We  out  1  IF/ID write enable.
- IFID_Flush  out  1  IF/ID clear to NOP.
- IDEX_We  out  1  ID/EX write enable.
- IDEX_Flush  out  1  ID/EX clear to bubble (all controls 0).
- EXMEM_We  out  1  EX/MEM write enable.
- EXMEM_Flush  out  1  EX/MEM clear to bubble.
- mem_err  out  1  sticky timeout error.
- stall_cnt  out  CNT_W  cycles with PC_We=0, saturating.
- flush_cnt  out  CNT_W  taken branches, saturating.

Behaviour:
- FSM states: RUN, MWAIT.
- All control outputs are combinational from state and inputs. Counters and mem_err are registered.

Reset:
- Rst=1 at a clock edge sets: state=RUN, timeout counter=0, mem_err=0, stall_cnt=0, flush_cnt=0.
- While Rst=1, outputs are forced regardless of state:
  - All _We = 0.
  - All _Flush = 1.
  - PC_Src = 0.
  - dmem_req = 0.
- A reset asserted mid-MWAIT abandons the access; the next cycle is RUN.

Definitions:
- memop = EXMEM_MemR | EXMEM_MemW.
- taken = EXMEM_Branch & EXMEM_zero.
- luh = IDEX_MemR & (IDEX_rt != 0) & (IDEX_rt == ID_rs | IDEX_rt == ID_rt).

Default outputs: all _We=1, all _Flush=0, PC_Src=0, dmem_req=0.

RUN priority (highest first):
1. memop:
   - dmem_req=1.
   - If dmem_ready: proceed normally, state stays RUN.
   - Else: freeze (PC_We=IFID_We=IDEX_We=EXMEM_We=0), next state MWAIT, timeout counter=1.
2. taken:
   - PC_Src=1, PC_We=1.
   - IFID_Flush=IDEX_Flush=EXMEM_Flush=1.
   - flush_cnt+1.
   - Overrides luh.
3. luh:
   - PC_We=0, IFID_We=0, IDEX_Flush=1.
   - One-cycle bubble; the hazard clears naturally as the load advances.

MWAIT:
- dmem_req=1; all four _We=0; no flushes.
- On dmem_ready: release the freeze this same cycle (enables=1); next state RUN.
- Otherwise the timeout counter increments. When it reaches MEM_TIMEOUT, mem_err is set (sticky until Rst) and the state stays MWAIT.
- Branch and luh are ignored in MWAIT; they are re-evaluated in RUN.

Counters:
- stall_cnt increments every non-reset cycle with PC_We=0. This includes luh and frozen memop cycles.
- Both counters saturate at all-ones.

Timing:
- Zero-latency control: decisions apply to the edge ending the current cycle.

Test Plan:
- Load-use: IDEX_MemR=1, IDEX_rt=5, ID_rs=5 for one cycle -> PC_We=0, IFID_We=0, IDEX_Flush=1 that cycle, stall_cnt=1. Same stimulus with IDEX_rt=0 -> no stall.
- Taken branch with simultaneous luh: EXMEM_Branch=1, EXMEM_zero=1, luh true -> PC_Src=1, PC_We=1, three flushes=1, flush_cnt=1, stall_cnt unchanged. EXMEM_zero=0 -> luh stall only.
- Memory wait: EXMEM_MemR=1, dmem_ready low 3 cycles then high -> dmem_req=1 for 4 cycles, enables 0 for 3 cycles, 1 on cycle 4, stall_cnt=3, state back to RUN.
- Timeout: EXMEM_MemW=1, dmem_ready held 0 for 20 cycles (MEM_TIMEOUT=15) -> mem_err rises after the 15th MWAIT cycle and stays 1 after dmem_ready; cleared only by Rst.
- Reset mid-MWAIT: Rst=1 during cycle 2 of a wait -> that cycle all _We=0, all _Flush=1, dmem_req=0; next cycle state RUN, counters 0, mem_err 0.
- Saturation: CNT_W=4 build, 20 luh cycles -> stall_cnt holds at 15.
